// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer fill engine.
//   AW/HW/WW     : word-address, row-count and width/stride widths
//   fill_state_e : fill sequencer states
//   fill_cmd_t   : latched fill command (mask field only with FB_FILL_MASK_EN)
//   FB_REGION_BIT: byte-address bit that selects the framebuffer region
package fb_pkg;
    localparam int AW            = 16;
    localparam int HW            = 11;
    localparam int WW            = 8;
    localparam int WORDS_W       = 19;
    localparam int FB_REGION_BIT = 19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    typedef struct packed {
        logic [AW-1:0] base;
        logic [WW-1:0] width;
        logic [HW-1:0] height;
        logic [WW-1:0] stride;
        logic [63:0]   pattern;
`ifdef FB_FILL_MASK_EN
        logic [7:0]    mask;
`endif
    } fill_cmd_t;
endpackage

// File: rtl/fb_rect_walker.sv
// Rectangle walker: produces the word offset (relative to the rectangle base)
// of the current fill beat and flags the last beat of the rectangle.
//   clk_i, rst_i : clock, synchronous active-high reset
//   start_i      : restart the walk at offset 0, column 0, row 0
//   advance_i    : current beat was written, step to the next word
//   width_i, height_i, stride_i : rectangle geometry (held stable while walking)
//   offset_o     : current word offset, wraps modulo 2^AW
//   last_o       : current beat is the final word of the rectangle
module fb_rect_walker
    import fb_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          advance_i,
    input  logic [WW-1:0] width_i,
    input  logic [HW-1:0] height_i,
    input  logic [WW-1:0] stride_i,
    output logic [AW-1:0] offset_o,
    output logic          last_o
);
    logic [AW-1:0] row_off_q;
    logic [AW-1:0] cur_off_q;
    logic [WW-1:0] col_q;
    logic [HW-1:0] row_q;
    logic          row_end;
    logic [AW-1:0] next_row;

    assign row_end  = (col_q == width_i - WW'(1));
    assign last_o   = row_end && (row_q == height_i - HW'(1));
    assign next_row = row_off_q + {{(AW-WW){1'b0}}, stride_i};
    assign offset_o = cur_off_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || start_i) begin
            row_off_q <= '0;
            cur_off_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
        end else if (advance_i) begin
            if (row_end) begin
                // Next row starts one stride past the previous row start,
                // independent of width, so overlapping rows are allowed.
                row_off_q <= next_row;
                cur_off_q <= next_row;
                col_q     <= '0;
                row_q     <= row_q + HW'(1);
            end else begin
                cur_off_q <= cur_off_q + AW'(1);
                col_q     <= col_q + WW'(1);
            end
        end
    end
endmodule

// File: rtl/fb_fill_ctrl.sv
// Rectangle-fill engine and framebuffer write-port arbiter.
// The CPU host path has absolute priority and passes straight through to the
// framebuffer port; the fill sequencer only writes on host-free cycles.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   cmd_*             : fill command (valid/ready handshake, accepted in IDLE)
//   abort_i           : cancel a running fill
//   host_*            : CPU framebuffer access, mirrored onto fb_* when host_en_i
//   fb_*              : framebuffer write port
//   busy_o, done_o    : fill running / one-cycle completion pulse
//   words_o           : words written by the last or current fill
// Optional: FB_FILL_MASK_EN adds cmd_mask_i, used as the fill byte enables.
module fb_fill_ctrl
    import fb_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [AW-1:0]      cmd_base_i,
    input  logic [WW-1:0]      cmd_width_i,
    input  logic [HW-1:0]      cmd_height_i,
    input  logic [WW-1:0]      cmd_stride_i,
    input  logic [63:0]        cmd_pattern_i,
`ifdef FB_FILL_MASK_EN
    input  logic [7:0]         cmd_mask_i,
`endif
    input  logic               abort_i,
    input  logic               host_en_i,
    input  logic [7:0]         host_we_i,
    input  logic [19:0]        host_addr_i,
    input  logic [63:0]        host_wrdata_i,
    output logic               fb_en_o,
    output logic [7:0]         fb_we_o,
    output logic [19:0]        fb_addr_o,
    output logic [63:0]        fb_wrdata_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [WORDS_W-1:0] words_o
);
    fill_state_e         state_q, state_d;
    fill_cmd_t           cmd_q;
    logic [WORDS_W-1:0]  words_q;
    logic                accept;
    logic                beat;
    logic                empty_cmd;
    logic                last;
    logic [AW-1:0]       offset;
    logic [AW-1:0]       cur_addr;
    logic [7:0]          beat_we;

`ifdef FB_FILL_MASK_EN
    assign empty_cmd = (cmd_width_i == '0) || (cmd_height_i == '0) || (cmd_mask_i == '0);
    assign beat_we   = cmd_q.mask;
`else
    assign empty_cmd = (cmd_width_i == '0) || (cmd_height_i == '0);
    assign beat_we   = 8'hFF;
`endif

    // Offsets wrap modulo 2^AW, so the absolute address wraps too.
    assign cur_addr = cmd_q.base + offset;
    assign words_o  = words_q;

    fb_rect_walker u_walker (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (accept),
        .advance_i (beat),
        .width_i   (cmd_q.width),
        .height_i  (cmd_q.height),
        .stride_i  (cmd_q.stride),
        .offset_o  (offset),
        .last_o    (last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        accept      = 1'b0;
        beat        = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    accept  = 1'b1;
                    state_d = empty_cmd ? DONE : RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (abort_i) begin
                    state_d = DONE;
                end else if (!host_en_i) begin
                    // A host access steals the cycle; the last beat simply
                    // waits, so DONE follows the first host-free cycle.
                    beat = 1'b1;
                    if (last) state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_q   <= '0;
            words_q <= '0;
        end else if (accept) begin
            cmd_q.base    <= cmd_base_i;
            cmd_q.width   <= cmd_width_i;
            cmd_q.height  <= cmd_height_i;
            cmd_q.stride  <= cmd_stride_i;
            cmd_q.pattern <= cmd_pattern_i;
`ifdef FB_FILL_MASK_EN
            cmd_q.mask    <= cmd_mask_i;
`endif
            words_q       <= '0;
        end else if (beat) begin
            words_q <= words_q + WORDS_W'(1);
        end
    end

    // Write-port mux: host passes through combinationally, fill beats come
    // from registered state, otherwise the port is quiet.
    always_comb begin
        fb_en_o     = 1'b0;
        fb_we_o     = '0;
        fb_addr_o   = '0;
        fb_wrdata_o = '0;
        if (host_en_i) begin
            fb_en_o     = 1'b1;
            fb_we_o     = host_we_i;
            fb_addr_o   = host_addr_i;
            fb_wrdata_o = host_wrdata_i;
        end else if (beat) begin
            fb_en_o                  = 1'b1;
            fb_we_o                  = beat_we;
            fb_addr_o[FB_REGION_BIT] = 1'b1;
            fb_addr_o[AW+2:3]        = cur_addr;
            fb_wrdata_o              = cmd_q.pattern;
        end
    end
endmodule
